overlay_c2x2_result_collector: RTL

//  Reader side of the C2x2 16x16 SIMD MAC overlay. Tracks every operand issue

---
 rtl/overlay_c2x2_result_collector.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/overlay_c2x2_result_collector.sv
// ---------------------------------------------------------------------------
// overlay_c2x2_result_collector
//
// Reader side of the C2x2 16x16 SIMD MAC overlay. Every accepted operand issue
// is tracked through a PIPE_LAT-deep {valid, mode} shift register. The overlay's
// registered sum/carry outputs are captured on the exact edge the issue reaches
// the end of that pipe. Captured results are queued in a first-word-fall-through
// FIFO and unpacked into 1/2/4 carry-extended lanes on the way out. Issue is
// throttled by credits because the overlay itself cannot stall.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous, active-low reset
//   iss_valid   in   1   operands are driven to the overlay this cycle
//   iss_mode    in   2   SIMD mode of this issue
//   iss_ready   out  1   credit available, issue permitted this cycle
//   ovl_s       in   32  overlay S_reg
//   ovl_carry   in   4   overlay result_SIMD_carry_out_reg
//   res_valid   out  1   FIFO head is valid
//   res_ready   in   1   consumer accepts the head
//   res_data    out  36  lane-unpacked head result (0 when res_valid=0)
//   res_mode    out  2   mode of the head entry (0 when res_valid=0)
//   fifo_level  out  3   FIFO occupancy, 0..FIFO_DEPTH
//   drop_err    out  1   sticky: iss_valid seen while iss_ready=0
// ---------------------------------------------------------------------------
module overlay_c2x2_result_collector #(
  parameter int PIPE_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               iss_valid,
  input  logic [1:0]                         iss_mode,
  output logic                               iss_ready,
  input  logic [31:0]                        ovl_s,
  input  logic [3:0]                         ovl_carry,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [35:0]                        res_data,
  output logic [1:0]                         res_mode,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               drop_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(PIPE_LAT + FIFO_DEPTH + 1);

  typedef struct packed {
    logic [1:0]  mode;
    logic [3:0]  c;
    logic [31:0] s;
  } entry_t;

  logic [PIPE_LAT-1:0] pipe_valid;
  logic [1:0]          pipe_mode [PIPE_LAT];

  entry_t              mem [FIFO_DEPTH];
  entry_t              head;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level;

  logic [CW-1:0]       inflight;
  logic [CW-1:0]       credits_used;
  logic                issue;
  logic                capture;
  logic                pop;

  // Credits: every slot the overlay could still hand us (in flight) plus every
  // queued entry consumes one. Only registered state feeds this, so a pop made
  // this cycle returns its credit on the following cycle.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      inflight = inflight + CW'(pipe_valid[i]);
    end
    credits_used = inflight + CW'(level);
  end

  assign iss_ready  = credits_used < CW'(FIFO_DEPTH);
  assign issue      = iss_valid & iss_ready;
  assign capture    = pipe_valid[PIPE_LAT-1];
  assign res_valid  = level != '0;
  assign pop        = res_valid & res_ready;
  assign fifo_level = level;

  // Tracking pipe mirrors the overlay latency; a rejected issue never enters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_mode[i] <= 2'b00;
      end
    end else begin
      pipe_valid[0] <= issue;
      pipe_mode[0]  <= iss_mode;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_mode[i]  <= pipe_mode[i-1];
      end
    end
  end

  // Storage needs no reset: entries are only visible while level says so.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= '{mode: pipe_mode[PIPE_LAT-1], c: ovl_carry, s: ovl_s};
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({capture, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_err <= 1'b0;
    end else if (iss_valid && !iss_ready) begin
      drop_err <= 1'b1;
    end
  end

  // Lane unpacking of the head entry; mode 11 is reserved and decodes as 00.
  assign head = mem[rd_ptr];

  always_comb begin
    res_data = '0;
    res_mode = 2'b00;
    if (res_valid) begin
      res_mode = head.mode;
      case (head.mode)
        2'b01:   res_data = {2'b00, head.c[3], head.s[31:16], head.c[1], head.s[15:0]};
        2'b10:   res_data = {head.c[3], head.s[31:24], head.c[2], head.s[23:16],
                             head.c[1], head.s[15:8],  head.c[0], head.s[7:0]};
        default: res_data = {3'b000, head.c[3], head.s};
      endcase
    end
  end

  // The overlay cannot stall, so a capture into a full FIFO would lose data;
  // credit control must make this impossible.
  assert property (@(posedge clk) disable iff (!reset)
                   !(capture && (level == LW'(FIFO_DEPTH))));

endmodule
